// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter (fetch read-only, load/store read/write) with ready wait and timeout.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module mem_bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {FETCH, LSU} owner_t;

    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_t        state, state_nx;
    owner_t        owner, owner_nx;
    owner_t        last_owner, last_owner_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [AW-1:0] addr_q, addr_nx;
    logic          we_q, we_nx;
    logic [DW-1:0] wdata_q, wdata_nx;
    logic [DW-1:0] rdata_q, rdata_nx;
    logic          err_q, err_nx;
    logic          grant_lsu;
    logic          timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the requester that did not own the previous transaction wins.
    assign grant_lsu = l_req && (!f_req || (last_owner == FETCH));
`else
    assign grant_lsu = l_req;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        cnt_nx        = cnt;
        addr_nx       = addr_q;
        we_nx         = we_q;
        wdata_nx      = wdata_q;
        rdata_nx      = rdata_q;
        err_nx        = err_q;
        case (state)
            IDLE: begin
                if (f_req || l_req) begin
                    cnt_nx   = '0;
                    state_nx = BUSY;
                    if (grant_lsu) begin
                        owner_nx = LSU;
                        addr_nx  = l_addr;
                        we_nx    = l_we;
                        wdata_nx = l_wdata;
                    end else begin
                        owner_nx = FETCH;
                        addr_nx  = f_addr;
                        we_nx    = 1'b0;
                        wdata_nx = '0;
                    end
                end
            end
            BUSY: begin
                // Ready takes precedence over a timeout expiring on the same edge.
                if (mem_ready) begin
                    rdata_nx = we_q ? '0 : mem_rdata;
                    err_nx   = 1'b0;
                    state_nx = DONE;
                end else if (timeout_hit) begin
                    rdata_nx = '0;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DONE: begin
                last_owner_nx = owner;
                err_nx        = 1'b0;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= FETCH;
            last_owner <= FETCH;
            cnt        <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            cnt        <= cnt_nx;
            addr_q     <= addr_nx;
            we_q       <= we_nx;
            wdata_q    <= wdata_nx;
            rdata_q    <= rdata_nx;
            err_q      <= err_nx;
        end
    end

    assign mem_cs    = (state == BUSY);
    assign mem_we    = we_q && mem_cs;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != IDLE);
    assign f_done    = (state == DONE) && (owner == FETCH);
    assign l_done    = (state == DONE) && (owner == LSU);
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int CW      = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_done;
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
        .rdata(rdata), .err(err),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit m_last_lsu = 1'b0;   // model: previous transaction owner was LSU

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_pick_lsu(input bit fr, input bit lr);
        if (!lr) return 1'b0;
        if (!fr) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !m_last_lsu;
`else
        return 1'b1;
`endif
    endfunction

    // One complete transaction. d = number of BUSY cycles with mem_ready low before it rises
    // (d >= TIMEOUT means memory never answers).
    task automatic do_txn(input bit fr, input bit lr, input bit lwe,
                          input logic [AW-1:0] fa, input logic [AW-1:0] la,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                          input int d, input bit drop);
        bit            lsu;
        int            exp_cycles;
        bit            exp_err;
        logic [DW-1:0] exp_rdata;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        bit            exp_we;
        int            cs;
        lsu        = model_pick_lsu(fr, lr);
        exp_err    = (d >= TIMEOUT);
        exp_cycles = exp_err ? TIMEOUT : d + 1;
        exp_rdata  = (exp_err || (lsu && lwe)) ? '0 : rd;
        exp_addr   = lsu ? la : fa;
        exp_we     = lsu && lwe;
        exp_wd     = lsu ? wd : '0;

        f_req = fr; l_req = lr; l_we = lwe;
        f_addr = fa; l_addr = la; l_wdata = wd;
        mem_rdata = rd; mem_ready = 1'b0;
        tick();
        cs = 0;
        while (mem_cs === 1'b1 && cs < 100) begin
            chk("busy_addr", 64'(mem_addr), 64'(exp_addr));
            chk("busy_we", 64'(mem_we), 64'(exp_we));
            chk("busy_wdata", 64'(mem_wdata), 64'(exp_wd));
            chk("busy_flags", {61'd0, busy, f_done, l_done}, 64'b100);
            mem_ready = (cs == d);
            if (drop) begin
                f_req = 1'b0;
                l_req = 1'b0;
            end
            f_addr  = AW'($urandom);
            l_addr  = AW'($urandom);
            l_wdata = $urandom;
            cs++;
            tick();
        end
        mem_ready = 1'b0;
        chk("cs_cycles", 64'(cs), 64'(exp_cycles));
        chk("f_done", 64'(f_done), 64'(!lsu));
        chk("l_done", 64'(l_done), 64'(lsu));
        chk("rdata", 64'(rdata), 64'(exp_rdata));
        chk("err", 64'(err), 64'(exp_err));
        chk("done_busy", 64'(busy), 64'd1);
        f_req = 1'b0;
        l_req = 1'b0;
        m_last_lsu = lsu;
        tick();
        chk("idle_flags", {59'd0, busy, mem_cs, f_done, l_done, err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        tick(); tick(); tick();
        chk("reset_ctl", {58'd0, busy, mem_cs, mem_we, f_done, l_done, err}, 64'd0);
        chk("reset_addr", 64'(mem_addr), 64'd0);
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        tick();

        // Fetch, zero-wait memory
        do_txn(1, 0, 0, 16'h0010, 16'h0000, 32'h0, 32'hDEADBEEF, 0, 0);
        // Store, ready in third BUSY cycle
        do_txn(0, 1, 1, 16'h0000, 16'h0200, 32'h12345678, 32'hCAFEF00D, 2, 0);
        // Load
        do_txn(0, 1, 0, 16'h0000, 16'h0300, 32'h55AA55AA, 32'h0BADC0DE, 1, 0);
        // Tie held for two transactions
        do_txn(1, 1, 0, 16'h0100, 16'h0400, 32'h0, 32'h11111111, 0, 0);
        do_txn(1, 1, 0, 16'h0104, 16'h0404, 32'h0, 32'h22222222, 1, 0);
        // Timeout on a load; then ready on the same edge as the timeout
        do_txn(0, 1, 0, 16'h0000, 16'h0500, 32'h0, 32'h33333333, 99, 0);
        do_txn(0, 1, 0, 16'h0000, 16'h0504, 32'h0, 32'h44444444, TIMEOUT - 1, 0);
        // Fetch request dropped after grant still completes
        do_txn(1, 0, 0, 16'h0600, 16'h0000, 32'h0, 32'h66666666, 3, 1);

        // Reset during the second BUSY cycle
        f_req = 1'b1; f_addr = 16'h0044; l_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h77777777;
        tick();
        chk("rst_mid_cs1", 64'(mem_cs), 64'd1);
        tick();
        chk("rst_mid_cs2", 64'(mem_cs), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_after", {60'd0, busy, mem_cs, f_done, l_done}, 64'd0);
        m_last_lsu = 1'b0;
        do_txn(1, 0, 0, 16'h0044, 16'h0000, 32'h0, 32'h77777777, 1, 0);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            bit fr, lr;
            int d;
            fr = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            if (!fr && !lr) fr = 1'b1;
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
            do_txn(fr, lr, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
                   $urandom, $urandom, d, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
